// File: rtl/pcie_align_pkg.sv
// -----------------------------------------------------------------------------
// pcie_align_pkg
//
// Shared constants and types for the PCIe single-lane comma aligner.
//   COMMA_RDN / COMMA_RDP : K28.5 in both running disparities. Bit 0 is the
//                           first-transmitted bit (a).
//   PAR_IDLE              : value ParOut drives while the lane is not locked,
//                           when PCIE_ALIGN_ZIDLE_EN is defined.
//   align_state_e         : symbol-lock state machine encoding.
//   is_comma()            : K28.5 compare shared by the detector.
// -----------------------------------------------------------------------------
package pcie_align_pkg;

  localparam logic [9:0] COMMA_RDN = 10'h17C;
  localparam logic [9:0] COMMA_RDP = 10'h283;
  localparam logic [9:0] PAR_IDLE  = 10'bzzzzzzzzzz;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    CHECK    = 2'd1,
    LOCKED   = 2'd2
  } align_state_e;

  function automatic logic is_comma(input logic [9:0] sym);
    return (sym == COMMA_RDN) || (sym == COMMA_RDP);
  endfunction

endpackage

// File: rtl/pcie_comma_aligner_if.sv
// -----------------------------------------------------------------------------
// pcie_comma_aligner_if
//
// Lane-side bundle between the serialiser/host and the comma aligner.
//   SerIn      : serial data, first-transmitted bit first
//   SerInIdle  : lane in electrical idle
//   ParOut     : aligned 10-bit symbol, bit 0 = first-transmitted bit
//   ParValid   : one-cycle pulse when ParOut is updated
//   Locked     : symbol lock established
//   CommaDet   : one-cycle flag after a comma was seen in the shifter
// Modports:
//   master : the side that drives the serial stream and consumes symbols
//   slave  : the aligner itself
// -----------------------------------------------------------------------------
interface pcie_comma_aligner_if;

  logic       SerIn;
  logic       SerInIdle;
  logic [9:0] ParOut;
  logic       ParValid;
  logic       Locked;
  logic       CommaDet;

  modport master (
    output SerIn, SerInIdle,
    input  ParOut, ParValid, Locked, CommaDet
  );

  modport slave (
    input  SerIn, SerInIdle,
    output ParOut, ParValid, Locked, CommaDet
  );

endinterface

// File: rtl/pcie_comma_detect.sv
// -----------------------------------------------------------------------------
// pcie_comma_detect
//
// 10-bit serial-in shifter with K28.5 comparison. Bits enter at the top and
// move toward bit 0, so after ten clocks shift_o[0] holds the first bit of the
// symbol. The comma compare is combinational on the registered shifter; the
// CommaDet flag is that compare delayed by one clock.
//
// Ports:
//   SerClk      in   bit clock
//   Reset       in   asynchronous, active-high reset
//   ser_i       in   serial data
//   shift_o     out  current shifter contents (registered)
//   comma_o     out  shifter currently holds a K28.5 (combinational)
//   comma_det_o out  registered copy of comma_o
// -----------------------------------------------------------------------------
module pcie_comma_detect
  import pcie_align_pkg::*;
(
  input  logic       SerClk,
  input  logic       Reset,
  input  logic       ser_i,
  output logic [9:0] shift_o,
  output logic       comma_o,
  output logic       comma_det_o
);

  logic [9:0] shift_q;
  logic [9:0] shift_d;
  logic       comma_det_q;

  assign shift_d = {ser_i, shift_q[9:1]};

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, regardless of statement order.
  // NOTE: the shifter is ten plain flops rather than a memory, so it is reset
  // along with everything else; a cleared shifter cannot fake a comma.
  always_ff @(posedge SerClk or posedge Reset) begin
    if (Reset) begin
      shift_q     <= '0;
      comma_det_q <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      comma_det_q <= comma_o;
    end
  end

  assign comma_o     = is_comma(shift_q);
  assign shift_o     = shift_q;
  assign comma_det_o = comma_det_q;

endmodule

// File: rtl/pcie_comma_aligner.sv
// -----------------------------------------------------------------------------
// pcie_comma_aligner
//
// Single-lane serial-to-10b receive aligner. Hunts for K28.5 commas in the
// serial stream, establishes symbol lock after LockCount consecutive
// boundary-aligned commas, tracks lock, and drops it after LossCount
// consecutive misaligned commas. Aligned symbols are presented one clock after
// their last bit was sampled.
//
// Parameters:
//   LockCount : aligned commas (including the first) needed to enter LOCKED
//   LossCount : consecutive misaligned commas in LOCKED that force a realign
//
// Ports:
//   SerClk : bit clock, all state changes on its rising edge
//   Reset  : asynchronous, active-high reset
//   bus    : pcie_comma_aligner_if.slave (SerIn, SerInIdle in;
//            ParOut, ParValid, Locked, CommaDet out)
//
// Build option:
//   PCIE_ALIGN_ZIDLE_EN : when defined, ParOut floats (all z) while Locked is
//                         low so the host sees electrical idle; the captured
//                         symbol is still kept internally. When undefined,
//                         ParOut always shows the captured symbol.
// -----------------------------------------------------------------------------
module pcie_comma_aligner
  import pcie_align_pkg::*;
#(
  parameter int unsigned LockCount = 3,
  parameter int unsigned LossCount = 2
) (
  input  logic                  SerClk,
  input  logic                  Reset,
  pcie_comma_aligner_if.slave   bus
);

  localparam int unsigned GoodW = $clog2(LockCount + 1);
  localparam int unsigned BadW  = $clog2(LossCount + 1);

  localparam logic [GoodW-1:0] GOOD_MAX   = GoodW'(LockCount);
  localparam logic [GoodW-1:0] GOOD_ONE   = GoodW'(1);
  localparam logic [BadW-1:0]  BAD_MAX    = BadW'(LossCount);
  localparam logic [3:0]       PHASE_LAST = 4'd9;

  // ---------------------------------------------------------------------------
  // Shifter and comma compare
  // ---------------------------------------------------------------------------
  logic [9:0] shift_w;
  logic       comma_w;
  logic       comma_det_w;

  pcie_comma_detect u_detect (
    .SerClk      (SerClk),
    .Reset       (Reset),
    .ser_i       (bus.SerIn),
    .shift_o     (shift_w),
    .comma_o     (comma_w),
    .comma_det_o (comma_det_w)
  );

  // ---------------------------------------------------------------------------
  // Lock state, phase, counters and output registers
  // ---------------------------------------------------------------------------
  align_state_e     state_q;
  logic [3:0]       phase_q;
  logic [GoodW-1:0] good_q;
  logic [BadW-1:0]  bad_q;
  logic [9:0]       par_q;
  logic             valid_q;
  logic             locked_q;

  logic             boundary;
  logic             aligned;
  logic             misaligned;
  logic             realign;
  logic [3:0]       phase_d;
  logic [GoodW-1:0] good_d;
  logic [BadW-1:0]  bad_d;

  // The shifter holds a complete symbol whenever phase has just reached 9,
  // because phase is zeroed on the edge that captures an aligning comma.
  assign boundary   = (phase_q == PHASE_LAST);
  assign aligned    = comma_w && boundary;
  assign misaligned = comma_w && !boundary;

  // Any comma while hunting, or an off-boundary comma while confirming,
  // restarts alignment on that comma. In LOCKED a stray comma only counts
  // toward loss of lock.
  assign realign = comma_w &&
                   ((state_q == UNLOCKED) || ((state_q == CHECK) && !boundary));

  assign phase_d = boundary ? 4'd0 : phase_q + 4'd1;

  // Both counters saturate at their thresholds instead of wrapping.
  assign good_d = (good_q == GOOD_MAX) ? good_q : good_q + GOOD_ONE;
  assign bad_d  = (bad_q  == BAD_MAX)  ? bad_q  : bad_q + BadW'(1);

  always_ff @(posedge SerClk or posedge Reset) begin
    if (Reset) begin
      state_q  <= UNLOCKED;
      phase_q  <= '0;
      good_q   <= '0;
      bad_q    <= '0;
      par_q    <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      phase_q <= phase_d;

      if (bus.SerInIdle) begin
        // Electrical idle wins over every other transition this cycle; the
        // shifter keeps running so the next comma can realign immediately.
        state_q  <= UNLOCKED;
        phase_q  <= '0;
        good_q   <= '0;
        bad_q    <= '0;
        locked_q <= 1'b0;
      end else if (realign) begin
        phase_q <= '0;
        good_q  <= GOOD_ONE;
        par_q   <= shift_w;
        valid_q <= 1'b1;
        if (GOOD_ONE == GOOD_MAX) begin
          state_q  <= LOCKED;
          locked_q <= 1'b1;
        end else begin
          state_q <= CHECK;
        end
      end else begin
        case (state_q)
          UNLOCKED: begin
            // Still hunting; nothing to emit.
          end

          CHECK: begin
            if (boundary) begin
              par_q   <= shift_w;
              valid_q <= 1'b1;
              // Non-comma symbols leave the running count untouched.
              if (aligned) begin
                good_q <= good_d;
                if (good_d == GOOD_MAX) begin
                  state_q  <= LOCKED;
                  locked_q <= 1'b1;
                end
              end
            end
          end

          LOCKED: begin
            if (boundary) begin
              par_q   <= shift_w;
              valid_q <= 1'b1;
            end
            // A single 10-bit match cannot be both, but aligned is checked
            // first so it would win.
            if (aligned) begin
              bad_q <= '0;
            end else if (misaligned) begin
              if (bad_d == BAD_MAX) begin
                state_q  <= UNLOCKED;
                bad_q    <= '0;
                locked_q <= 1'b0;
              end else begin
                bad_q <= bad_d;
              end
            end
          end

          default: begin
            state_q  <= UNLOCKED;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
`ifdef PCIE_ALIGN_ZIDLE_EN
  assign bus.ParOut = locked_q ? par_q : PAR_IDLE;
`else
  assign bus.ParOut = par_q;
`endif

  assign bus.ParValid = valid_q;
  assign bus.Locked   = locked_q;
  assign bus.CommaDet = comma_det_w;

endmodule

// File: tb/tb_pcie_comma_aligner.sv
// -----------------------------------------------------------------------------
// tb_pcie_comma_aligner
//
// Self-checking bench for pcie_comma_aligner. A behavioural model tracks the
// bit history, the lock mode and the edge at which the current alignment was
// taken; symbol boundaries follow from edge arithmetic. Every cycle the DUT
// outputs are compared with the model, and directed scenarios add explicit
// checks on lock timing and emitted symbols. Works with or without
// PCIE_ALIGN_ZIDLE_EN defined.
// -----------------------------------------------------------------------------
module tb_pcie_comma_aligner;

  localparam int LOCK_N = 3;
  localparam int LOSS_N = 2;

  localparam logic [9:0] K_RDN = 10'h17C;
  localparam logic [9:0] K_RDP = 10'h283;
  localparam logic [9:0] D102  = 10'h2AA;

  logic SerClk = 1'b0;
  logic Reset;

  pcie_comma_aligner_if bus ();

  pcie_comma_aligner #(
    .LockCount (LOCK_N),
    .LossCount (LOSS_N)
  ) dut (
    .SerClk (SerClk),
    .Reset  (Reset),
    .bus    (bus)
  );

  always #5 SerClk = ~SerClk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Emitted symbols and the cycle they appeared on.
  logic [9:0] pv_sym[$];
  int         pv_cyc[$];

  task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int         m_mode;      // 0 hunting, 1 confirming, 2 locked
  int         m_good;
  int         m_bad;
  int         m_edge;
  int         m_anchor;    // edge at which the current alignment was taken
  logic [9:0] m_par;
  logic       m_valid;
  logic       m_locked;
  logic       m_cdet;
  bit         hist[$];     // last ten bits, hist[0] oldest

  function automatic logic [9:0] exp_par();
`ifdef PCIE_ALIGN_ZIDLE_EN
    return m_locked ? m_par : 10'bzzzzzzzzzz;
`else
    return m_par;
`endif
  endfunction

  task automatic model_reset();
    m_mode   = 0;
    m_good   = 0;
    m_bad    = 0;
    m_par    = '0;
    m_valid  = 1'b0;
    m_locked = 1'b0;
    m_cdet   = 1'b0;
    hist.delete();
    for (int i = 0; i < 10; i++) hist.push_back(1'b0);
  endtask

  task automatic model_step(input bit b, input bit idle);
    logic [9:0] sym;
    bit         match;
    bit         bnd;
    for (int i = 0; i < 10; i++) sym[i] = hist[i];
    match = (sym == K_RDN) || (sym == K_RDP);
    m_edge++;
    m_cdet  = match;
    m_valid = 1'b0;
    bnd = (m_mode != 0) && (((m_edge - m_anchor) % 10) == 0);
    if (idle) begin
      m_mode = 0;
      m_good = 0;
      m_bad  = 0;
    end else if (match && (m_mode == 0 || (m_mode == 1 && !bnd))) begin
      m_anchor = m_edge;
      m_good   = 1;
      m_par    = sym;
      m_valid  = 1'b1;
      m_mode   = (LOCK_N <= 1) ? 2 : 1;
    end else if (m_mode == 1) begin
      if (bnd) begin
        m_par   = sym;
        m_valid = 1'b1;
        if (match) begin
          m_good = (m_good + 1 > LOCK_N) ? LOCK_N : m_good + 1;
          if (m_good >= LOCK_N) m_mode = 2;
        end
      end
    end else if (m_mode == 2) begin
      if (bnd) begin
        m_par   = sym;
        m_valid = 1'b1;
      end
      if (match && bnd) begin
        m_bad = 0;
      end else if (match) begin
        m_bad++;
        if (m_bad >= LOSS_N) begin
          m_mode = 0;
          m_bad  = 0;
        end
      end
    end
    m_locked = (m_mode == 2);
    void'(hist.pop_front());
    hist.push_back(b);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers (called at a falling edge, return at a falling edge)
  // ---------------------------------------------------------------------------
  task automatic cycle(input bit b, input bit idle);
    bus.SerIn     = b;
    bus.SerInIdle = idle;
    @(posedge SerClk);
    model_step(b, idle);
    @(negedge SerClk);
    cyc++;
    check("par_out",   bus.ParOut,             exp_par());
    check("par_valid", {9'd0, bus.ParValid},   {9'd0, m_valid});
    check("locked",    {9'd0, bus.Locked},     {9'd0, m_locked});
    check("comma_det", {9'd0, bus.CommaDet},   {9'd0, m_cdet});
    if (bus.ParValid === 1'b1) begin
      pv_sym.push_back(bus.ParOut);
      pv_cyc.push_back(cyc);
    end
  endtask

  task automatic send_bits(input logic [9:0] w, input int from);
    for (int i = from; i < 10; i++) cycle(w[i], 1'b0);
  endtask

  task automatic send_sym(input logic [9:0] w);
    send_bits(w, 0);
  endtask

  task automatic reset_mid(input string tag);
    #2 Reset = 1'b1;
    #1;
    model_reset();
    check({tag, "_par_out"},   bus.ParOut,           exp_par());
    check({tag, "_par_valid"}, {9'd0, bus.ParValid}, 10'd0);
    check({tag, "_locked"},    {9'd0, bus.Locked},   10'd0);
    check({tag, "_comma_det"}, {9'd0, bus.CommaDet}, 10'd0);
    @(negedge SerClk);
    Reset = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  logic [9:0] s2_exp [4];
  logic [9:0] w;
  int         r;
  int         off;

  initial begin
    s2_exp = '{10'h17C, 10'h2AA, 10'h283, 10'h17C};
    Reset         = 1'b1;
    bus.SerIn     = 1'b0;
    bus.SerInIdle = 1'b0;
    m_edge   = 0;
    m_anchor = 0;
    model_reset();

    // Reset state.
    @(negedge SerClk);
    check("rst_par_out",   bus.ParOut,           exp_par());
    check("rst_par_valid", {9'd0, bus.ParValid}, 10'd0);
    check("rst_locked",    {9'd0, bus.Locked},   10'd0);
    check("rst_comma_det", {9'd0, bus.CommaDet}, 10'd0);
    Reset = 1'b0;

    // Thirty zero bits: nothing happens.
    repeat (30) cycle(1'b0, 1'b0);
`ifdef PCIE_ALIGN_ZIDLE_EN
    check("s1_par_out", bus.ParOut, 10'bzzzzzzzzzz);
`else
    check("s1_par_out", bus.ParOut, 10'h000);
`endif
    check("s1_locked", {9'd0, bus.Locked}, 10'd0);
    check("s1_pulses", 10'(pv_sym.size()), 10'd0);

    // Random offset, then K28.5-, D10.2, K28.5+, K28.5-.
    pv_sym.delete();
    pv_cyc.delete();
    off = $urandom_range(0, 7);
    repeat (off) cycle(1'b0, 1'b0);
    send_sym(K_RDN);
    send_sym(D102);
    send_sym(K_RDP);
    send_sym(K_RDN);
    check("s2_not_yet_locked", {9'd0, bus.Locked}, 10'd0);
    cycle(K_RDP[0], 1'b0);
    check("s2_locked_rise", {9'd0, bus.Locked}, 10'd1);
    check("s2_pulses", 10'(pv_sym.size()), 10'd4);
    for (int i = 0; i < 4 && i < pv_sym.size(); i++)
      check("s2_symbol", pv_sym[i], s2_exp[i]);
    for (int i = 1; i < 4 && i < pv_cyc.size(); i++)
      check("s2_spacing", 10'(pv_cyc[i] - pv_cyc[i-1]), 10'd10);
    send_bits(K_RDP, 1);

    // One-bit slip, then two misaligned commas lose lock; three more relock.
    send_sym(K_RDN);
    send_bits(D102, 1);
    send_sym(K_RDN);
    send_sym(K_RDP);
    check("s3_still_locked", {9'd0, bus.Locked}, 10'd1);
    cycle(K_RDN[0], 1'b0);
    check("s3_lock_lost", {9'd0, bus.Locked}, 10'd0);
    send_bits(K_RDN, 1);
    send_sym(K_RDP);
    send_sym(K_RDN);
    check("s3_not_yet_relocked", {9'd0, bus.Locked}, 10'd0);
    cycle(D102[0], 1'b0);
    check("s3_relocked", {9'd0, bus.Locked}, 10'd1);
    send_bits(D102, 1);

    // Misaligned comma, aligned comma, misaligned comma: lock holds.
    repeat (5) cycle(1'b0, 1'b0);
    send_sym(K_RDN);
    repeat (5) cycle(1'b0, 1'b0);
    send_sym(K_RDP);
    repeat (5) cycle(1'b0, 1'b0);
    send_sym(K_RDN);
    repeat (5) cycle(1'b0, 1'b0);
    send_sym(K_RDP);
    cycle(D102[0], 1'b0);
    check("s4_lock_held", {9'd0, bus.Locked}, 10'd1);
    send_bits(D102, 1);

    // One-cycle electrical idle mid-symbol while locked.
    send_sym(K_RDN);
    for (int i = 0; i < 10; i++) begin
      cycle(D102[i], i == 5);
      if (i == 5) begin
        check("s5_idle_unlock", {9'd0, bus.Locked},   10'd0);
        check("s5_idle_valid",  {9'd0, bus.ParValid}, 10'd0);
      end
    end
    pv_sym.delete();
    pv_cyc.delete();
    repeat (3) send_sym(D102);
    check("s5_no_pulses", 10'(pv_sym.size()), 10'd0);
    send_sym(K_RDN);
    cycle(1'b0, 1'b0);
    check("s5_comma_pulse", {9'd0, bus.ParValid}, 10'd1);

    // Asynchronous reset while confirming alignment.
    repeat (3) cycle(1'b0, 1'b0);
    reset_mid("s6");

    // Randomised traffic.
    for (int s = 0; s < 250; s++) begin
      r = $urandom_range(0, 39);
      if (r < 14) begin
        send_sym(($urandom_range(0, 1) == 1) ? K_RDP : K_RDN);
      end else if (r < 22) begin
        send_sym(D102);
      end else if (r < 32) begin
        w = 10'($urandom);
        send_sym(w);
      end else if (r < 36) begin
        w = 10'($urandom);
        send_bits(w, $urandom_range(1, 9));
      end else if (r < 39) begin
        repeat ($urandom_range(1, 3)) cycle(1'($urandom), 1'b1);
      end else begin
        reset_mid("rand_reset");
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
